// File: rtl/dram_sram_bridge_pkg.sv
// Shared constants for the DRAM-strobe to SRAM bridge: FSM encoding and
// synchroniser/address-width defaults used by the board top.
package dram_sram_bridge_pkg;

  localparam int MIN_SYNC_STAGES  = 2;
  localparam int DEFAULT_ROW_BITS = 9;

  typedef logic [2:0] bridge_state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ROW     = 3'd1;
  localparam logic [2:0] ST_COL     = 3'd2;
  localparam logic [2:0] ST_REFRESH = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  function automatic int clamp_sync_stages(input int stages);
    return (stages < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : stages;
  endfunction

endpackage

// File: rtl/dram_sram_bridge_sync_bus.sv
// N-bit multi-flop synchroniser; every bit resets to RST_VAL so buses that
// share a depth stay cycle-aligned after the crossing.
module sync_bus
  import dram_sram_bridge_pkg::*;
#(
  parameter int   WIDTH   = 1,
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  localparam int DEPTH = clamp_sync_stages(STAGES);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift chain: stage 0 samples the asynchronous input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= {WIDTH{RST_VAL}};
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dram_sram_bridge.sv
// Decodes multiplexed DRAM strobes into static SRAM control/address, with
// page-mode column cycles, CBR refresh counting and a RAS-stuck watchdog.
module dram_sram_bridge
  import dram_sram_bridge_pkg::*;
#(
  parameter int ROW_BITS     = DEFAULT_ROW_BITS,
  parameter int LANES        = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int RAS_TIMEOUT  = 1023,
  parameter int REF_CNT_BITS = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ROW_BITS-1:0]     a_in,
  input  logic                    ras_n,
  input  logic [LANES-1:0]        cas_n,
  input  logic                    we_in_n,
  input  logic                    oe_in_n,
  output logic [2*ROW_BITS-1:0]   sram_addr,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic [LANES-1:0]        sram_lane_n,
  output logic [REF_CNT_BITS-1:0] refresh_count,
  output logic                    ras_timeout
);

  localparam int STB_W = LANES + 3;
  localparam int WD_W  = $clog2(RAS_TIMEOUT + 1);

  logic [STB_W-1:0]    stb_s;
  logic [ROW_BITS-1:0] a_s;
  logic                ras_s;
  logic [LANES-1:0]    cas_s;
  logic                we_s;
  logic                oe_s;

  sync_bus #(.WIDTH(STB_W), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_stb (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     ({oe_in_n, we_in_n, cas_n, ras_n}),
    .q_o     (stb_s)
  );

  sync_bus #(.WIDTH(ROW_BITS), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_addr (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (a_in),
    .q_o     (a_s)
  );

  assign {oe_s, we_s, cas_s, ras_s} = stb_s;

  logic                    ras_prev_q;
  logic [LANES-1:0]        cas_prev_q;
  bridge_state_t           state_q, state_d;
  logic [ROW_BITS-1:0]     row_q, row_d;
  logic [2*ROW_BITS-1:0]   addr_q, addr_d;
  logic                    ce_n_q, ce_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    we_n_q, we_n_d;
  logic [LANES-1:0]        lane_n_q, lane_n_d;
  logic                    write_q, write_d;
  logic [REF_CNT_BITS-1:0] ref_q, ref_d;
  logic                    to_q, to_d;
  logic [WD_W-1:0]         wd_q, wd_d;

  logic ras_fall_s;
  logic cas_any_low_s;
  logic cas_was_low_s;
  logic wd_fire_s;

  assign ras_fall_s    = ras_prev_q & ~ras_s;
  assign cas_any_low_s = ~(&cas_s);
  // A CAS already low before this RAS fall means CBR; a same-cycle fall is an access.
  assign cas_was_low_s = ~(&cas_prev_q) & cas_any_low_s;
  assign wd_fire_s     = ~ras_s & (wd_q == WD_W'(RAS_TIMEOUT - 1));

  // Watchdog count: runs while RAS is low, saturates at the timeout.
  always_comb begin
    wd_d = wd_q;
    if (ras_s) begin
      wd_d = {WD_W{1'b0}};
    end else if (wd_q != WD_W'(RAS_TIMEOUT)) begin
      wd_d = wd_q + WD_W'(1);
    end else begin
      wd_d = wd_q;
    end
  end

  // Strobe decode FSM; all SRAM outputs are registered.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    addr_d   = addr_q;
    ce_n_d   = ce_n_q;
    oe_n_d   = oe_n_q;
    we_n_d   = we_n_q;
    lane_n_d = lane_n_q;
    write_d  = write_q;
    ref_d    = ref_q;
    to_d     = to_q | wd_fire_s;
    case (state_q)
      ST_IDLE: begin
        if (ras_fall_s && cas_was_low_s) begin
          ref_d   = ref_q + REF_CNT_BITS'(1);
          state_d = ST_REFRESH;
        end else if (ras_fall_s) begin
          row_d   = a_s;
          ce_n_d  = 1'b0;
          state_d = ST_ROW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ROW: begin
        if (ras_s) begin
          {ce_n_d, oe_n_d, we_n_d} = 3'b111;
          lane_n_d = {LANES{1'b1}};
          state_d  = ST_IDLE;
        end else if (cas_any_low_s) begin
          addr_d   = {a_s, row_q};
          lane_n_d = cas_s;
          write_d  = ~we_s;
          we_n_d   = we_s;
          oe_n_d   = we_s ? oe_s : 1'b1;
          state_d  = ST_COL;
        end else begin
          state_d = ST_ROW;
        end
      end
      ST_COL: begin
        if (ras_s) begin
          {ce_n_d, oe_n_d, we_n_d} = 3'b111;
          lane_n_d = {LANES{1'b1}};
          state_d  = ST_IDLE;
        end else if (cas_any_low_s) begin
          lane_n_d = cas_s;
          we_n_d   = ~write_q;
          oe_n_d   = write_q ? 1'b1 : oe_s;
        end else begin
          {oe_n_d, we_n_d} = 2'b11;
          lane_n_d = {LANES{1'b1}};
          state_d  = ST_ROW;
        end
      end
      ST_REFRESH, ST_HOLD: begin
        if (ras_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        {ce_n_d, oe_n_d, we_n_d} = 3'b111;
        lane_n_d = {LANES{1'b1}};
        state_d  = ST_IDLE;
      end
    endcase
    if (wd_fire_s) begin
      {ce_n_d, oe_n_d, we_n_d} = 3'b111;
      lane_n_d = {LANES{1'b1}};
      state_d  = ST_HOLD;
    end else begin
      to_d = to_q;
    end
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ras_prev_q <= 1'b1;
      cas_prev_q <= {LANES{1'b1}};
      state_q    <= ST_IDLE;
      row_q      <= {ROW_BITS{1'b0}};
      addr_q     <= {(2*ROW_BITS){1'b0}};
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      lane_n_q   <= {LANES{1'b1}};
      write_q    <= 1'b0;
      ref_q      <= {REF_CNT_BITS{1'b0}};
      to_q       <= 1'b0;
      wd_q       <= {WD_W{1'b0}};
    end else begin
      ras_prev_q <= ras_s;
      cas_prev_q <= cas_s;
      state_q    <= state_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      lane_n_q   <= lane_n_d;
      write_q    <= write_d;
      ref_q      <= ref_d;
      to_q       <= to_d;
      wd_q       <= wd_d;
    end
  end

  assign sram_addr     = addr_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_we_n     = we_n_q;
  assign sram_lane_n   = lane_n_q;
  assign refresh_count = ref_q;
  assign ras_timeout   = to_q;

endmodule

// File: tb/tb_dram_sram_bridge.sv
// Directed bench: one bridge with a short refresh counter for access/refresh
// checks, one with a 15-cycle watchdog, both driven by the same strobes.
module tb_dram_sram_bridge;

  logic        clk;
  logic        reset_n;
  logic [8:0]  a_in;
  logic        ras_n;
  logic [1:0]  cas_n;
  logic        we_in_n;
  logic        oe_in_n;

  logic [17:0] a_addr, w_addr;
  logic        a_ce_n, a_oe_n, a_we_n, w_ce_n, w_oe_n, w_we_n;
  logic [1:0]  a_lane_n, w_lane_n;
  logic [1:0]  a_refcnt;
  logic [15:0] w_refcnt;
  logic        a_to, w_to;

  int tests_run;
  int tests_failed;
  logic [17:0] exp_addr;

  dram_sram_bridge #(.ROW_BITS(9), .LANES(2), .SYNC_STAGES(2),
                     .RAS_TIMEOUT(1023), .REF_CNT_BITS(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .a_in(a_in), .ras_n(ras_n), .cas_n(cas_n),
    .we_in_n(we_in_n), .oe_in_n(oe_in_n), .sram_addr(a_addr), .sram_ce_n(a_ce_n),
    .sram_oe_n(a_oe_n), .sram_we_n(a_we_n), .sram_lane_n(a_lane_n),
    .refresh_count(a_refcnt), .ras_timeout(a_to)
  );

  dram_sram_bridge #(.ROW_BITS(9), .LANES(2), .SYNC_STAGES(2),
                     .RAS_TIMEOUT(15), .REF_CNT_BITS(16)) dut_w (
    .clk(clk), .reset_n(reset_n), .a_in(a_in), .ras_n(ras_n), .cas_n(cas_n),
    .we_in_n(we_in_n), .oe_in_n(oe_in_n), .sram_addr(w_addr), .sram_ce_n(w_ce_n),
    .sram_oe_n(w_oe_n), .sram_we_n(w_we_n), .sram_lane_n(w_lane_n),
    .refresh_count(w_refcnt), .ras_timeout(w_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n = 1'b0;
    a_in    = 9'h000;
    ras_n   = 1'b1;
    cas_n   = 2'b11;
    we_in_n = 1'b1;
    oe_in_n = 1'b1;
    tick(2);
    check_eq("rst_addr", {14'd0, a_addr}, 32'd0);
    check_eq("rst_strobes", {27'd0, a_ce_n, a_oe_n, a_we_n, a_lane_n}, 32'h1F);
    check_eq("rst_refcnt", {30'd0, a_refcnt}, 32'd0);
    check_eq("rst_timeout", {31'd0, a_to}, 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Single read, lane 0
    a_in = 9'h0A5; ras_n = 1'b0;
    tick(3);
    check_eq("rd_ce_row", {31'd0, a_ce_n}, 32'd0);
    a_in = 9'h13C; cas_n = 2'b10; oe_in_n = 1'b0;
    tick(3);
    check_eq("rd_addr", {14'd0, a_addr}, 32'h278A5);
    check_eq("rd_strobes", {27'd0, a_ce_n, a_oe_n, a_we_n, a_lane_n}, {27'd0, 5'b00110});
    cas_n = 2'b11;
    tick(3);
    check_eq("rd_cas_up", {27'd0, a_ce_n, a_oe_n, a_we_n, a_lane_n}, {27'd0, 5'b01111});
    ras_n = 1'b1; oe_in_n = 1'b1;
    tick(3);
    check_eq("rd_ras_up", {31'd0, a_ce_n}, 32'd1);
    check_eq("rd_addr_hold", {14'd0, a_addr}, 32'h278A5);

    // Early write, both lanes
    a_in = 9'h055; ras_n = 1'b0;
    tick(3);
    we_in_n = 1'b0;
    tick(1);
    a_in = 9'h1FF; cas_n = 2'b00;
    tick(3);
    check_eq("wr_addr", {14'd0, a_addr}, 32'h3FE55);
    check_eq("wr_strobes", {27'd0, a_ce_n, a_oe_n, a_we_n, a_lane_n}, {27'd0, 5'b01000});
    cas_n = 2'b11;
    tick(3);
    check_eq("wr_cas_up", {27'd0, a_oe_n, a_we_n, a_lane_n, a_ce_n}, {27'd0, 5'b11110});
    ras_n = 1'b1; we_in_n = 1'b1;
    tick(3);

    // Page mode: one row, three columns
    a_in = 9'h0C3; ras_n = 1'b0;
    tick(3);
    for (int i = 1; i <= 3; i++) begin
      a_in = 9'(i); cas_n = 2'b00;
      tick(3);
      exp_addr = {9'(i), 9'h0C3};
      check_eq($sformatf("pg_addr%0d", i), {14'd0, a_addr}, {14'd0, exp_addr});
      check_eq($sformatf("pg_ce%0d", i), {31'd0, a_ce_n}, 32'd0);
      cas_n = 2'b11;
      tick(3);
      check_eq($sformatf("pg_gap_ce%0d", i), {30'd0, a_ce_n, a_oe_n}, 32'd1);
    end
    ras_n = 1'b1;
    tick(3);

    // CBR refresh x3, then wrap of the 2-bit counter
    for (int k = 1; k <= 4; k++) begin
      cas_n = 2'b00;
      tick(3);
      ras_n = 1'b0;
      tick(3);
      check_eq($sformatf("cbr_ce%0d", k), {31'd0, a_ce_n}, 32'd1);
      check_eq($sformatf("cbr_cnt%0d", k), {30'd0, a_refcnt}, {30'd0, 2'(k)});
      ras_n = 1'b1; cas_n = 2'b11;
      tick(3);
    end

    // Watchdog on the 15-cycle instance
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check_eq("wd_rst", {31'd0, w_to}, 32'd0);
    a_in = 9'h011; ras_n = 1'b0;
    tick(12);
    check_eq("wd_early", {31'd0, w_to}, 32'd0);
    check_eq("wd_ce_row", {31'd0, w_ce_n}, 32'd0);
    tick(8);
    check_eq("wd_fired", {31'd0, w_to}, 32'd1);
    check_eq("wd_ce_hold", {31'd0, w_ce_n}, 32'd1);
    ras_n = 1'b1;
    tick(3);
    a_in = 9'h022; ras_n = 1'b0;
    tick(3);
    a_in = 9'h033; cas_n = 2'b01; oe_in_n = 1'b0;
    tick(3);
    check_eq("wd_acc_addr", {14'd0, w_addr}, 32'h06622);
    check_eq("wd_acc_strobes", {27'd0, w_ce_n, w_oe_n, w_we_n, w_lane_n}, {27'd0, 5'b00101});
    check_eq("wd_sticky", {31'd0, w_to}, 32'd1);
    cas_n = 2'b11; oe_in_n = 1'b1;
    tick(3);
    ras_n = 1'b1;
    tick(3);

    // Reset in the middle of a write
    a_in = 9'h044; ras_n = 1'b0;
    tick(3);
    we_in_n = 1'b0; a_in = 9'h088; cas_n = 2'b00;
    tick(3);
    check_eq("mw_we_active", {31'd0, a_we_n}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mw_rst_strobes", {27'd0, a_ce_n, a_oe_n, a_we_n, a_lane_n}, 32'h1F);
    check_eq("mw_rst_addr", {14'd0, a_addr}, 32'd0);
    check_eq("mw_rst_refcnt", {30'd0, a_refcnt}, 32'd0);
    ras_n = 1'b1; cas_n = 2'b11; we_in_n = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
